// File: rtl/load_store_unit.sv
// load_store_unit: turns one load or store request into data-memory word accesses.
//   Handles byte, halfword and word sizes. Sub-word stores are done as read-modify-write.
// Latency from the accept edge to resp_valid:
//   fault 1 cycle, SW 2 cycles, load 3 cycles, SB/SH 4 cycles.
// Backpressure: req_ready is high only in IDLE. Request inputs are ignored while busy.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req_*                   request handshake and latched request fields
//   resp_*                  one-cycle completion pulse with load data and fault flag
//   mem_*                   word-aligned memory port; read data returns one cycle after the address
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_address,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_read_address,
    output logic [XLEN-1:0] mem_write_address,
    output logic [XLEN-1:0] mem_data_write,
    output logic            mem_write_enabled,
    input  logic [XLEN-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

    state_t      state;
    logic        is_store;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [15:0] wdata_lo;   // only B/H stores merge, so the low half is enough

    assign req_ready = (state == IDLE);

    function automatic logic req_fault(input logic store, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic flt;
        case (f3)
            3'd1, 3'd5:       flt = a[0];
            3'd2:             flt = (a != 2'b00);
            3'd3, 3'd6, 3'd7: flt = 1'b1;
            default:          flt = 1'b0;
        endcase
        if (store && f3 > 3'd2) flt = 1'b1;
        return flt;
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{(XLEN-8){b[7]}}, b};
            3'd4:    r = {{(XLEN-8){1'b0}}, b};
            3'd1:    r = {{(XLEN-16){h[15]}}, h};
            3'd5:    r = {{(XLEN-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Little-endian lane replace. funct3 0 means byte and anything else reaching here is a halfword.
    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [15:0] d);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] lane;
        if (f3 == 3'd0) begin
            mask = XLEN'(8'hFF) << {off, 3'b000};
            lane = XLEN'(d[7:0]) << {off, 3'b000};
        end else begin
            mask = XLEN'(16'hFFFF) << {off[1], 4'b0000};
            lane = XLEN'(d) << {off[1], 4'b0000};
        end
        return (w & ~mask) | (lane & mask);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            is_store          <= 1'b0;
            funct3            <= 3'd0;
            offset            <= 2'd0;
            wdata_lo          <= 16'd0;
            resp_valid        <= 1'b0;
            resp_fault        <= 1'b0;
            resp_rdata        <= '0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_data_write    <= '0;
            mem_write_enabled <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store          <= req_store;
                        funct3            <= req_funct3;
                        offset            <= req_address[1:0];
                        wdata_lo          <= req_wdata[15:0];
                        mem_read_address  <= {req_address[XLEN-1:2], 2'b00};
                        mem_write_address <= {req_address[XLEN-1:2], 2'b00};
                        if (req_fault(req_store, req_funct3, req_address[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_store && req_funct3 == 3'd2) begin
                            // A full-word store needs no read, so it goes straight to WRITE.
                            state             <= WRITE;
                            mem_write_enabled <= 1'b1;
                            mem_data_write    <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    if (is_store) begin
                        state             <= WRITE;
                        mem_write_enabled <= 1'b1;
                        mem_data_write    <= merge(mem_data_out, funct3, offset, wdata_lo);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= extract(mem_data_out, funct3, offset);
                    end
                end
                WRITE: begin
                    state             <= RESP;
                    mem_write_enabled <= 1'b0;
                    resp_valid        <= 1'b1;
                    resp_fault        <= 1'b0;
                    resp_rdata        <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_data_write;
    logic        mem_write_enabled;
    logic [31:0] mem_data_out;

    logic        mem_init;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_store         (req_store),
        .req_funct3        (req_funct3),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_fault        (resp_fault),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_data_write    (mem_data_write),
        .mem_write_enabled (mem_write_enabled),
        .mem_data_out      (mem_data_out)
    );

    // Data memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        mem_data_out <= mem[mem_read_address[9:2]];
        if (mem_init) begin
            mem[64] <= 32'h8899AABB;
            mem[65] <= 32'h00000000;
        end else if (mem_write_enabled) begin
            mem[mem_write_address[9:2]] <= mem_data_write;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch 8 cycles. Latency j means resp_valid is seen in the j-th cycle after the accept edge.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_fault, input int exp_writes,
                           input logic [31:0] exp_waddr, input logic [31:0] exp_wdat);
        int first, nresp, nwr;
        logic [31:0] rd, wa, wdv;
        logic flt;
        first = 0; nresp = 0; nwr = 0; rd = '0; wa = '0; wdv = '0; flt = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_address = addr; req_wdata = wd;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            if (resp_valid) begin
                if (first == 0) first = j;
                nresp++;
                rd  = resp_rdata;
                flt = resp_fault;
            end
            if (mem_write_enabled) begin
                nwr++;
                wa  = mem_write_address;
                wdv = mem_data_write;
            end
        end
        check({tag, " latency"}, 32'(first), 32'(exp_lat));
        check({tag, " resp count"}, 32'(nresp), 32'd1);
        check({tag, " rdata"}, rd, exp_rdata);
        check({tag, " fault"}, 32'(flt), 32'(exp_fault));
        check({tag, " writes"}, 32'(nwr), 32'(exp_writes));
        if (nwr > 0) begin
            check({tag, " waddr"}, wa, exp_waddr);
            check({tag, " wdata"}, wdv, exp_wdat);
        end
    endtask

    logic [31:0] exp_q [3];
    logic [31:0] got_q [3];
    logic [2:0]  b2b_f3 [3];
    logic [31:0] b2b_addr [3];

    initial begin
        int nacc, ngot, idx, nwr, nresp;
        logic pending;
        reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_address = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_fault", 32'(resp_fault), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst mem_we", 32'(mem_write_enabled), 32'd0);
        check("rst rd_addr", mem_read_address, 32'd0);
        check("rst wr_addr", mem_write_address, 32'd0);
        check("rst wr_data", mem_data_write, 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd1);

        // Loads from 0x8899AABB
        run_req("LB 0x101", 1'b0, 3'd0, 32'h101, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0, 0, 0);
        check("LB rd_addr", mem_read_address, 32'h100);
        run_req("LBU 0x103", 1'b0, 3'd4, 32'h103, 32'h0, 3, 32'h00000088, 1'b0, 0, 0, 0);
        check("rdata hold", resp_rdata, 32'h00000088);
        run_req("LH 0x102", 1'b0, 3'd1, 32'h102, 32'h0, 3, 32'hFFFF8899, 1'b0, 0, 0, 0);
        run_req("LHU 0x100", 1'b0, 3'd5, 32'h100, 32'h0, 3, 32'h0000AABB, 1'b0, 0, 0, 0);
        run_req("LW 0x100", 1'b0, 3'd2, 32'h100, 32'h0, 3, 32'h8899AABB, 1'b0, 0, 0, 0);

        // Stores
        run_req("SB 0x102", 1'b1, 3'd0, 32'h102, 32'h12345677, 4, 32'h0, 1'b0, 1, 32'h100, 32'h8877AABB);
        check("SB mem", mem[64], 32'h8877AABB);
        check("store rdata zero", resp_rdata, 32'h0);
        run_req("SW 0x104", 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'h104, 32'hDEADBEEF);
        check("SW mem", mem[65], 32'hDEADBEEF);
        run_req("SH 0x102", 1'b1, 3'd1, 32'h102, 32'h5555CAFE, 4, 32'h0, 1'b0, 1, 32'h100, 32'hCAFEAABB);
        check("SH mem", mem[64], 32'hCAFEAABB);

        // Faults
        run_req("LW first", 1'b0, 3'd2, 32'h104, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 0, 0);
        run_req("LH 0x103 fault", 1'b0, 3'd1, 32'h103, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);
        run_req("SB f3=4 fault", 1'b1, 3'd4, 32'h100, 32'h11, 1, 32'h0, 1'b1, 0, 0, 0);
        run_req("f3=3 fault", 1'b0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);
        run_req("LW 0x102 fault", 1'b0, 3'd2, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 0, 0);
        check("mem after faults", mem[64], 32'hCAFEAABB);

        // Reset during CAPTURE of a SH
        nwr = 0; nresp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd1; req_address = 32'h102; req_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);                 // READ
        req_valid = 1'b0;
        @(negedge clk);                 // CAPTURE
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst-mid ready", 32'(req_ready), 32'd1);
        for (int j = 0; j < 6; j++) begin
            if (mem_write_enabled) nwr++;
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        check("rst-mid writes", 32'(nwr), 32'd0);
        check("rst-mid resps", 32'(nresp), 32'd0);
        check("rst-mid mem", mem[64], 32'hCAFEAABB);

        // Back-to-back loads with req_valid held high
        b2b_f3[0] = 3'd2; b2b_addr[0] = 32'h100; exp_q[0] = 32'hCAFEAABB;
        b2b_f3[1] = 3'd4; b2b_addr[1] = 32'h104; exp_q[1] = 32'h000000EF;
        b2b_f3[2] = 3'd1; b2b_addr[2] = 32'h106; exp_q[2] = 32'hFFFFDEAD;
        for (int i = 0; i < 3; i++) got_q[i] = '0;
        nacc = 0; ngot = 0; idx = 0; pending = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = b2b_f3[0]; req_address = b2b_addr[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 3) begin
                    req_funct3 = b2b_f3[idx]; req_address = b2b_addr[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) begin
                if (ngot < 3) got_q[ngot] = resp_rdata;
                ngot++;
            end
            if (req_valid && req_ready) begin
                pending = 1'b1;
                nacc++;
            end
            @(negedge clk);
        end
        check("b2b accepts", 32'(nacc), 32'd3);
        check("b2b resps", 32'(ngot), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("b2b rdata %0d", i), got_q[i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
